// File: rtl/mem_access_if.sv
// MEM-stage request/response and split addr/data bus bundle
// for mem_access_unit.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store data-memory access unit with bus-timeout watchdog.
// Optional ALIGN_CHECK_EN: misaligned half/word rejected before the bus.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic       clk,
  input logic       resetn,
  mem_access_if.slave mif
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       ld_uns;

  logic       op_ok;
  logic       op_wr;
  logic       op_uns;
  logic [1:0] op_sz;
  logic       mis;

  always_comb begin
    op_ok  = 1'b1;
    op_wr  = 1'b0;
    op_uns = 1'b0;
    op_sz  = 2'd0;
    unique case (1'b1)
      (mif.req_op == 6'b100000): op_sz = 2'd0;
      (mif.req_op == 6'b100001): op_sz = 2'd1;
      (mif.req_op == 6'b100011): op_sz = 2'd2;
      (mif.req_op == 6'b100100): op_uns = 1'b1;
      (mif.req_op == 6'b100101): begin
        op_uns = 1'b1;
        op_sz  = 2'd1;
      end
      (mif.req_op == 6'b101000): op_wr = 1'b1;
      (mif.req_op == 6'b101001): begin
        op_wr = 1'b1;
        op_sz = 2'd1;
      end
      (mif.req_op == 6'b101011): begin
        op_wr = 1'b1;
        op_sz = 2'd2;
      end
      default: op_ok = 1'b0;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  assign mis = ((op_sz == 2'd1) && mif.req_addr[0]) ||
               ((op_sz == 2'd2) && (mif.req_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  function automatic logic [3:0] strb_of(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    unique case (sz)
      2'd0:    strb_of = 4'b0001 << lo;
      2'd1:    strb_of = lo[1] ? 4'b1100 : 4'b0011;
      default: strb_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lanes_of(
    input logic [1:0]  sz,
    input logic [31:0] wd
  );
    unique case (sz)
      2'd0:    lanes_of = {4{wd[7:0]}};
      2'd1:    lanes_of = {2{wd[15:0]}};
      default: lanes_of = wd;
    endcase
  endfunction

  // Narrow loads pick their lane from the latched low address bits.
  function automatic logic [31:0] extract(
    input logic [1:0]  sz,
    input logic        uns,
    input logic [1:0]  lo,
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    unique case (sz)
      2'd0:    extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  assign mif.stall = (state == ADDR) | (state == DATA) |
                     ((state == IDLE) & mif.req_valid & op_ok);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      ld_uns         <= 1'b0;
      mif.req_ready  <= 1'b1;
      mif.resp_valid <= 1'b0;
      mif.resp_rdata <= 32'd0;
      mif.resp_err   <= 2'b00;
      mif.bus_req    <= 1'b0;
      mif.bus_wr     <= 1'b0;
      mif.bus_size   <= 2'd0;
      mif.bus_addr   <= 32'd0;
      mif.bus_wstrb  <= 4'd0;
      mif.bus_wdata  <= 32'd0;
    end else begin
      mif.resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mif.req_valid && op_ok) begin
            mif.req_ready <= 1'b0;
            mif.bus_wr    <= op_wr;
            mif.bus_size  <= op_sz;
            mif.bus_addr  <= mif.req_addr;
            mif.bus_wstrb <= strb_of(op_sz, mif.req_addr[1:0]);
            mif.bus_wdata <= lanes_of(op_sz, mif.req_wdata);
            ld_uns        <= op_uns;
            cnt           <= 8'd0;
            if (mis) begin
              state          <= RESP;
              mif.resp_valid <= 1'b1;
              mif.resp_rdata <= 32'd0;
              mif.resp_err   <= op_wr ? 2'b10 : 2'b01;
            end else begin
              state       <= ADDR;
              mif.bus_req <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (mif.bus_addr_ok) begin
            mif.bus_req <= 1'b0;
            cnt         <= 8'd0;
            state       <= DATA;
          end else if (cnt == TLAST) begin
            mif.bus_req    <= 1'b0;
            mif.resp_valid <= 1'b1;
            mif.resp_rdata <= 32'd0;
            mif.resp_err   <= 2'b11;
            state          <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (mif.bus_data_ok) begin
            mif.resp_valid <= 1'b1;
            mif.resp_err   <= 2'b00;
            mif.resp_rdata <= mif.bus_wr ? 32'd0 :
              extract(mif.bus_size, ld_uns,
                      mif.bus_addr[1:0], mif.bus_rdata);
            state          <= RESP;
          end else if (cnt == TLAST) begin
            mif.resp_valid <= 1'b1;
            mif.resp_rdata <= 32'd0;
            mif.resp_err   <= 2'b11;
            state          <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          mif.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: reference model, bus
// responder with random wait states and a response monitor.
module tb_mem_access_unit;

  localparam int TO = 8;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } rexp_t;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bexp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_resp = 0;

  int s_adly = 0;
  int s_ddly = 0;
  bit s_hang_a = 1'b0;
  bit s_hang_d = 1'b0;
  bit s_rst = 1'b0;

  rexp_t rq[$];
  bexp_t bq[$];
  logic [31:0] mem [logic [31:0]];

  mem_access_if mif ();

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .resetn(resetn),
    .mif   (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wi);
    if (!mem.exists(wi)) mem[wi] = $urandom;
    return mem[wi];
  endfunction

  // Bus responder: optional wait states, optional hang in either phase.
  initial begin : slave
    logic [31:0] sw;
    bexp_t eb;
    mif.bus_addr_ok = 1'b0;
    mif.bus_data_ok = 1'b0;
    mif.bus_rdata   = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (mif.bus_req && !s_hang_a) begin
        for (int i = 0; i < s_adly; i++) begin
          chk("req_held", mif.bus_req, 1);
          chk("stall_addr", mif.stall, 1);
          @(posedge clk);
          #2;
        end
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bus_req addr=%h", mif.bus_addr);
        end else begin
          eb = bq.pop_front();
          chk("bus_wr", mif.bus_wr, eb.wr);
          chk("bus_size", mif.bus_size, eb.sz);
          chk("bus_addr", mif.bus_addr, eb.addr);
          chk("bus_wstrb", mif.bus_wstrb, eb.strb);
          chk("bus_wdata", mif.bus_wdata, eb.wdata);
        end
        mif.bus_addr_ok = 1'b1;
        @(posedge clk);
        #2;
        mif.bus_addr_ok = 1'b0;
        if (!s_hang_d) begin
          for (int i = 0; i < s_ddly; i++) begin
            if (!s_rst) chk("stall_data", mif.stall, 1);
            @(posedge clk);
            #2;
          end
          if (mif.bus_wr) begin
            sw = mem_rd(mif.bus_addr >> 2);
            for (int i = 0; i < 4; i++)
              if (mif.bus_wstrb[i]) sw[8*i +: 8] = mif.bus_wdata[8*i +: 8];
            mem[mif.bus_addr >> 2] = sw;
            mif.bus_rdata = $urandom;
          end else begin
            mif.bus_rdata = mem_rd(mif.bus_addr >> 2);
          end
          mif.bus_data_ok = 1'b1;
          @(posedge clk);
          #2;
          mif.bus_data_ok = 1'b0;
          mif.bus_rdata   = $urandom;
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rexp_t er;
    if (resetn && mif.resp_valid) begin
      n_resp++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp rdata=%h err=%0d",
                 mif.resp_rdata, mif.resp_err);
      end else begin
        er = rq.pop_front();
        chk("resp_rdata", mif.resp_rdata, er.rdata);
        chk("resp_err", {30'd0, mif.resp_err}, {30'd0, er.err});
        chk("resp_lat", cyc + 1 - er.acc, er.lat);
        chk("stall_resp", mif.stall, 0);
      end
    end
  end

  // hang: 0 none, 1 addr_ok never comes, 2 data_ok never comes.
  task automatic do_req(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int adly,
                        input int ddly, input int hang, input bit rst_mid);
    int n;
    int lane;
    int target;
    bit sg;
    bit st;
    bit bus;
    logic [31:0] m;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] wr;
    rexp_t er;
    bexp_t eb;
    n = 4;
    sg = 1'b0;
    st = 1'b0;
    case (op)
      LB:  begin n = 1; sg = 1'b1; end
      LH:  begin n = 2; sg = 1'b1; end
      LW:  n = 4;
      LBU: n = 1;
      LHU: n = 2;
      SB:  begin n = 1; st = 1'b1; end
      SH:  begin n = 2; st = 1'b1; end
      default: begin n = 4; st = 1'b1; end
    endcase
    lane = (n == 1) ? int'(a % 4) : (n == 2) ? int'(a % 4) / 2 * 2 : 0;
    m = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    w = mem_rd(a >> 2);
    v = (w >> (8 * lane)) & m;
    if (sg && v[8*n-1]) v = v | ~m;
    wr = 32'd0;
    for (int i = 0; i < 4 / n; i++) wr = wr | ((wd & m) << (8 * n * i));
    eb.wr = st;
    eb.sz = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    eb.addr = a;
    eb.strb = 4'(((1 << n) - 1) << lane);
    eb.wdata = wr;
    er.rdata = st ? 32'd0 : v;
    er.err = 2'd0;
    er.lat = 3 + adly + ddly;
    bus = (hang != 1);
    if (hang == 1) begin
      er.rdata = 32'd0;
      er.err = 2'd3;
      er.lat = TO + 1;
    end
    if (hang == 2) begin
      er.rdata = 32'd0;
      er.err = 2'd3;
      er.lat = adly + TO + 2;
    end
`ifdef ALIGN_CHECK_EN
    if (int'(a % n) != 0) begin
      er.rdata = 32'd0;
      er.err = st ? 2'd2 : 2'd1;
      er.lat = 1;
      bus = 1'b0;
    end
`endif
    if (bus) bq.push_back(eb);
    s_adly = adly;
    s_ddly = ddly;
    s_hang_a = (hang == 1);
    s_hang_d = (hang == 2);
    s_rst = rst_mid;
    for (int i = 0; i < 50 && !mif.req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk("ready_before_req", mif.req_ready, 1);
    mif.req_valid = 1'b1;
    mif.req_op = op;
    mif.req_addr = a;
    mif.req_wdata = wd;
    @(negedge clk);
    chk("stall_accept", mif.stall, 1);
    @(posedge clk);
    #1;
    mif.req_valid = 1'b0;
    er.acc = cyc;
    target = n_resp + 1;
    if (!rst_mid) begin
      rq.push_back(er);
      for (int i = 0; i < 200 && n_resp < target; i++) @(posedge clk);
      #1;
      chk("resp_arrived", 32'(n_resp >= target), 1);
    end else begin
      @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      chk("rst_mid_bus_req", mif.bus_req, 0);
      chk("rst_mid_ready", mif.req_ready, 1);
      repeat (12) @(posedge clk);
      #1;
      chk("rst_mid_no_resp", n_resp, target - 1);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog sim time expired");
    $fatal(1);
  end

  initial begin : main
    logic [5:0] ops [8];
    int r;
    int hg;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    mif.req_valid = 1'b0;
    mif.req_op = 6'd0;
    mif.req_addr = 32'd0;
    mif.req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", mif.req_ready, 1);
    chk("rst_stall", mif.stall, 0);
    chk("rst_outs", 32'(|{mif.resp_valid, mif.resp_rdata, mif.resp_err,
                          mif.bus_req, mif.bus_wr, mif.bus_size,
                          mif.bus_addr, mif.bus_wstrb, mif.bus_wdata}), 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    mem[32'h40] = 32'h1122_3344;
    do_req(LW, 32'h100, 32'd0, 0, 0, 0, 1'b0);
    mem[32'h40] = 32'h80FF_FFFF;
    do_req(LB, 32'h103, 32'd0, 0, 0, 0, 1'b0);
    do_req(LBU, 32'h103, 32'd0, 0, 0, 0, 1'b0);
    do_req(SH, 32'h202, 32'h0000_BEEF, 0, 0, 0, 1'b0);
    do_req(LW, 32'h104, 32'd0, 3, 5, 0, 1'b0);
    do_req(LH, 32'h10A, 32'd0, 0, 0, 2, 1'b0);
    do_req(SW, 32'h10C, 32'h1234_5678, 0, 0, 1, 1'b0);
    do_req(LW, 32'h101, 32'd0, 0, 0, 0, 1'b0);

    mif.req_valid = 1'b1;
    mif.req_op = 6'b000111;
    mif.req_addr = 32'h300;
    @(negedge clk);
    chk("unk_stall", mif.stall, 0);
    @(posedge clk);
    #1;
    mif.req_valid = 1'b0;
    chk("unk_ready", mif.req_ready, 1);
    chk("unk_no_bus", mif.bus_req, 0);

    do_req(LW, 32'h110, 32'd0, 0, 6, 0, 1'b1);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 15);
      hg = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      do_req(ops[$urandom_range(0, 7)], 32'h1000 + $urandom_range(0, 63),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             hg, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
